imem_loader: RTL

Program loader that fills the 64 x 16-bit instruction memory from a byte stream, typically a UART receiver. It frames a length-prefixed, XOR-checksummed image into 16-bit words and drives a registered write port into the instruction store. It holds the core in reset (`cpu_hold`) until a complete, verified image is in memory.

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_loader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/imem_pkg.sv
// Shared instruction-memory parameters and the loader state encoding.
package imem_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DATA_W = 16;

  typedef enum logic [2:0] {
    S_WAIT_LEN = 3'd0,
    S_HI       = 3'd1,
    S_LO       = 3'd2,
    S_CHECK    = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: frames LEN / 2*LEN data bytes / CHK into
// 16-bit words, writes them into the instruction memory through a
// registered port and releases the core only after the checksum matches.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reload,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_waddr,
  output logic [IMEM_DATA_W-1:0] mem_wdata,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   err
);

  localparam int         DEPTH   = 2**ADDR_W;
  localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

  // Running XOR checksum over the data bytes.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  loader_state_t   state_q, state_d;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] cnt_inc;
  logic [7:0]      hi_q;
  logic [7:0]      chk_q;
  logic            xfer;
  logic            take;
  logic            len_bad;
  logic            last_word;
  logic            wr_d;

  // Status outputs decode the registered state only.
  assign in_ready = (state_q == S_WAIT_LEN) || (state_q == S_HI) ||
                    (state_q == S_LO) || (state_q == S_CHECK);
  assign cpu_hold = (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);

  assign xfer      = in_valid && in_ready;
  // A byte arriving together with reload is dropped.
  assign take      = xfer && !reload;
  assign len_bad   = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH_9);
  // Counter is one bit wider than the address so LEN = DEPTH ends cleanly.
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_word = (cnt_inc == len_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_WAIT_LEN;
    else     state_q <= state_d;
  end

  // Next-state decode and write-issue strobe.
  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    if (reload) begin
      state_d = S_WAIT_LEN;
    end else if (xfer) begin
      unique case (state_q)
        S_WAIT_LEN: state_d = len_bad ? S_ERR : S_HI;
        S_HI:       state_d = S_LO;
        S_LO: begin
          wr_d    = 1'b1;
          state_d = last_word ? S_CHECK : S_HI;
        end
        S_CHECK:    state_d = (in_data == chk_q) ? S_DONE : S_ERR;
        default:    state_d = state_q;
      endcase
    end
  end

  // Framing datapath: length, word counter, high byte and checksum.
  always_ff @(posedge clk) begin
    if (take) begin
      unique case (state_q)
        S_WAIT_LEN: begin
          if (!len_bad) begin
            len_q <= in_data[ADDR_W:0];
            cnt_q <= '0;
            chk_q <= '0;
          end
        end
        S_HI: begin
          hi_q  <= in_data;
          chk_q <= chk_fold(chk_q, in_data);
        end
        S_LO: begin
          chk_q <= chk_fold(chk_q, in_data);
          cnt_q <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  // Registered write port; one-cycle strobe the cycle after the LO byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= wr_d;
      if (wr_d) begin
        mem_waddr <= cnt_q[ADDR_W-1:0];
        mem_wdata <= {hi_q, in_data};
      end
    end
  end

endmodule
